gshare_branch_predictor: RTL and testbench



---
 rtl/gshare_branch_predictor.sv | 55 +++++
 tb/tb_gshare_branch_predictor.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/gshare_branch_predictor.sv
// gshare_branch_predictor: pc XOR global history selects a 2-bit saturating counter in the PHT.
// Latency: predict_taken is combinational from pc; training and the history shift land on the next rising clk.
// Backpressure: none. One branch retires every cycle, unconditionally.
module gshare_branch_predictor #(
    parameter int          PC_WIDTH  = 8,
    parameter int          GHR_WIDTH = 8,      // must equal PC_WIDTH so the XOR covers the full index
    parameter logic [1:0]  PHT_INIT  = 2'b01   // weakly not-taken
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PC_WIDTH-1:0] pc,
    input  logic                branch_taken,
    output logic                predict_taken
);

    localparam int PHT_DEPTH = 2 ** PC_WIDTH;

    logic [GHR_WIDTH-1:0] ghr_q;
    logic [GHR_WIDTH-1:0] ghr_d;
    logic [GHR_WIDTH-1:0] ghr;      // named copy of the history, kept visible for probing
    logic [PC_WIDTH-1:0]  index;    // full-width pc ^ history, no folding
    logic [1:0]           pht_q [PHT_DEPTH];
    logic [1:0]           cnt;
    logic [1:0]           pht_d;

    assign ghr   = ghr_q;
    assign index = pc ^ ghr_q;

    // Look up the addressed counter and form the prediction plus its trained value.
    always_comb begin
        cnt           = pht_q[index];
        predict_taken = cnt[1];
        pht_d         = cnt;
        if (branch_taken) begin
            if (cnt != 2'b11) pht_d = cnt + 2'b01;
        end else begin
            if (cnt != 2'b00) pht_d = cnt - 2'b01;
        end
        ghr_d = {ghr_q[GHR_WIDTH-2:0], branch_taken};
    end

    // Reset clears history and the whole table in one edge; otherwise train the pre-edge index and shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            ghr_q <= '0;
            for (int i = 0; i < PHT_DEPTH; i++) begin
                pht_q[i] <= PHT_INIT;
            end
        end else begin
            ghr_q        <= ghr_d;
            pht_q[index] <= pht_d;
        end
    end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Bench for gshare_branch_predictor: directed scenarios then random traffic, checked by a scoreboard.
// Stimulus pushes expected responses computed from an array-based reference model.
// A separate monitor pops one entry per cycle and compares prediction, history, index and counter.
module tb_gshare_branch_predictor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] pc = 8'h00;
    logic       branch_taken = 1'b0;
    logic       predict_taken;

    gshare_branch_predictor #(
        .PC_WIDTH (8),
        .GHR_WIDTH(8),
        .PHT_INIT (2'b01)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .branch_taken (branch_taken),
        .predict_taken(predict_taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pc;
        int taken;
        int pred;
        int ghr;
        int idx;
        int cnt;
    } exp_t;

    exp_t q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int pred_total   = 0;
    int pred_correct = 0;

    // Reference model: history as an integer, table as an integer array.
    int m_ghr;
    int m_pht [256];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ghr = 0;
        for (int i = 0; i < 256; i++) m_pht[i] = 1;
    endtask

    // Drive one cycle's branch, queue what the DUT must show, then advance the model past the coming edge.
    task automatic issue(input int p, input int t, input int r);
        exp_t e;
        int   idx;
        @(posedge clk);
        #1;
        pc           = p[7:0];
        branch_taken = t[0];
        reset        = r[0];
        idx   = (p ^ m_ghr) % 256;
        e.pc    = p;
        e.taken = t;
        e.idx   = idx;
        e.ghr   = m_ghr;
        e.cnt   = m_pht[idx];
        e.pred  = (m_pht[idx] >= 2) ? 1 : 0;
        q.push_back(e);
        if (r != 0) begin
            model_reset();
        end else begin
            if (t != 0) m_pht[idx] = (m_pht[idx] == 3) ? 3 : m_pht[idx] + 1;
            else        m_pht[idx] = (m_pht[idx] == 0) ? 0 : m_pht[idx] - 1;
            m_ghr = (m_ghr * 2 + t) % 256;
        end
    endtask

    task automatic expect_pht(input int addr, input int val);
        chk("pht_probe", int'(dut.pht_q[addr]), val);
    endtask

    // Monitor: each cycle, once inputs have settled, compare the DUT against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #4;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("predict_taken", int'(predict_taken), e.pred);
                chk("ghr", int'(dut.ghr), e.ghr);
                chk("index", int'(dut.index), e.idx);
                chk("pht_addressed", int'(dut.pht_q[e.idx]), e.cnt);
                pred_total++;
                if (int'(predict_taken) == e.taken) pred_correct++;
            end
        end
    end

    initial begin
        int p;
        int t;
        int r;
        int waitc;
        model_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // Held in reset: history zero, every pc predicts not-taken.
        issue(8'h00, 0, 1);
        issue(8'h10, 0, 1);
        issue(8'hAA, 0, 1);
        issue(8'hFF, 0, 1);

        // pc=10 taken 11 times: history ramps to FF, counter at EF saturates.
        for (int i = 0; i < 11; i++) issue(8'h10, 1, 0);

        // Mid-stream reset discards that training.
        issue(8'h10, 0, 1);
        expect_pht(8'hEF, 3);
        issue(8'h10, 1, 0);
        expect_pht(8'hEF, 1);
        chk("ghr_after_reset", int'(dut.ghr), 0);
        issue(8'h20, 0, 1);

        // pc=20 not-taken x5: history stays 0, counter falls to 00 and stays.
        for (int i = 0; i < 5; i++) issue(8'h20, 0, 0);
        issue(8'h20, 0, 1);
        expect_pht(8'h20, 0);

        // Saturation at EF: many takens, then one not-taken leaves 10 which still predicts taken.
        for (int i = 0; i < 14; i++) issue(8'h10, 1, 0);
        expect_pht(8'hEF, 3);
        issue(8'h10, 0, 0);
        issue(8'h11, 1, 0);
        expect_pht(8'hEF, 2);
        chk("ghr_after_nt", int'(dut.ghr), 8'hFE);
        issue(8'h30, 0, 1);

        // Alternating T,N at pc=30 from reset.
        for (int i = 0; i < 10; i++) issue(8'h30, (i % 2 == 0) ? 1 : 0, 0);

        // Random traffic with a hot pc, biased outcomes and occasional resets.
        for (int i = 0; i < 400; i++) begin
            p = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : 8'h44;
            t = ($urandom_range(0, 3) != 0) ? 1 : 0;
            r = ($urandom_range(0, 99) == 0) ? 1 : 0;
            issue(p, t, r);
        end

        waitc = 0;
        while (q.size() > 0 && waitc < 20) begin
            @(posedge clk);
            waitc++;
        end
        #5;
        chk("scoreboard_drain", q.size(), 0);

        $display("Predictor accuracy: %0d correct of %0d predictions", pred_correct, pred_total);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
